// File: rtl/fft_output_reorder.sv
// Reorders bit-reversed Y0/Y1 butterfly pairs into a natural-order sample stream through a ping-pong buffer.
// Latency: out_valid rises the cycle after a frame's last pair is accepted; then one sample per cycle.
// Backpressure: in_ready drops while the write bank is still full; out_ready low holds the current sample.
module fft_output_reorder #(
  parameter int N     = 16,
  parameter int LOG2N = 4,
  parameter int DW    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_y0_re,
  input  logic [DW-1:0]    in_y0_im,
  input  logic [DW-1:0]    in_y1_re,
  input  logic [DW-1:0]    in_y1_im,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_re,
  output logic [DW-1:0]    out_im,
  output logic [LOG2N-1:0] out_idx,
  output logic             out_last,
  output logic             err_drop
);

  localparam int HALF = N / 2;

  // Two banks of {re, im} words; contents survive reset.
  logic [2*DW-1:0]    bank_q [2][N];

  logic [LOG2N-2:0]   wr_cnt_q, wr_cnt_d;
  logic [LOG2N-1:0]   rd_cnt_q, rd_cnt_d;
  logic               wr_bank_q, wr_bank_d;
  logic               rd_bank_q, rd_bank_d;
  logic [1:0]         full_q, full_d;
  logic               err_drop_q, err_drop_d;

  logic               wr_fire, rd_fire, wr_last, rd_last;
  logic [LOG2N-1:0]   addr0, addr1;
  logic [2*DW-1:0]    rd_word;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
    return r;
  endfunction

  assign in_ready  = !full_q[wr_bank_q];
  assign out_valid = full_q[rd_bank_q];
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;
  assign wr_last   = (wr_cnt_q == (LOG2N-1)'(HALF-1));
  assign rd_last   = (rd_cnt_q == LOG2N'(N-1));

  // Pair p lands at the bit-reversed addresses of stream positions 2p and 2p+1.
  assign addr0 = bitrev({wr_cnt_q, 1'b0});
  assign addr1 = bitrev({wr_cnt_q, 1'b1});

  assign rd_word  = bank_q[rd_bank_q][rd_cnt_q];
  assign out_re   = rd_word[2*DW-1:DW];
  assign out_im   = rd_word[DW-1:0];
  assign out_idx  = rd_cnt_q;
  assign out_last = out_valid && rd_last;
  assign err_drop = err_drop_q;

  // Next-state for counters, bank pointers, full flags and the sticky drop flag.
  always_comb begin
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    full_d     = full_q;
    err_drop_d = err_drop_q;

    if (in_valid && !in_ready) err_drop_d = 1'b1;

    if (wr_fire) begin
      if (wr_last) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
        wr_cnt_d          = '0;
      end else begin
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
    end

    // A fill and a drain in the same cycle always touch different banks.
    if (rd_fire) begin
      if (rd_last) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = !rd_bank_q;
        rd_cnt_d          = '0;
      end else begin
        rd_cnt_d = rd_cnt_q + 1'b1;
      end
    end
  end

  // Control state register with asynchronous reset; partial frames are abandoned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      full_q     <= 2'b00;
      err_drop_q <= 1'b0;
    end else begin
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      full_q     <= full_d;
      err_drop_q <= err_drop_d;
    end
  end

  // Buffer write: both samples of an accepted pair go into the current write bank.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      bank_q[wr_bank_q][addr0] <= {in_y0_re, in_y0_im};
      bank_q[wr_bank_q][addr1] <= {in_y1_re, in_y1_im};
    end
  end

endmodule

// File: tb/tb_fft_output_reorder.sv
// Scoreboard bench for fft_output_reorder at N=16: directed frames, stalls, overflow drop and reset.
// Expected natural-order sample k is the frame sample at stream index bitrev4(k), from a fixed table.
// A negedge monitor compares every presented sample against the queue head and pops on transfer.
module tb_fft_output_reorder;

  localparam int N = 16;
  localparam int DW = 16;
  localparam int LOG2N = 4;

  typedef struct packed {
    logic [DW-1:0]    re;
    logic [DW-1:0]    im;
    logic [LOG2N-1:0] idx;
    logic             last;
  } sb_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [DW-1:0]    in_y0_re = '0, in_y0_im = '0, in_y1_re = '0, in_y1_im = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [DW-1:0]    out_re, out_im;
  logic [LOG2N-1:0] out_idx;
  logic             out_last;
  logic             err_drop;

  int checks = 0;
  int errors = 0;
  int out_cnt = 0;
  int stall_cnt = 0;
  int base;
  sb_t sb[$];

  // Hand-computed 4-bit bit reversal of k.
  int brv [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
  logic [DW-1:0] fr_re [16];
  logic [DW-1:0] fr_im [16];

  fft_output_reorder #(.N(N), .LOG2N(LOG2N), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_y0_re(in_y0_re), .in_y0_im(in_y0_im), .in_y1_re(in_y1_re), .in_y1_im(in_y1_im),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im), .out_idx(out_idx), .out_last(out_last),
    .err_drop(err_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every presented sample with the queue head, pop on transfer.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got idx %0d re 0x%0h with empty scoreboard", out_idx, out_re);
      end else begin
        chk("out_re", 32'(out_re), 32'(sb[0].re));
        chk("out_im", 32'(out_im), 32'(sb[0].im));
        chk("out_idx", 32'(out_idx), 32'(sb[0].idx));
        chk("out_last", 32'(out_last), 32'(sb[0].last));
        if (out_ready) begin
          void'(sb.pop_front());
          out_cnt++;
        end
      end
    end
  end

  task automatic send_pair(input logic [DW-1:0] a_re, a_im, b_re, b_im);
    logic rdy;
    in_valid = 1'b1;
    in_y0_re = a_re; in_y0_im = a_im; in_y1_re = b_re; in_y1_im = b_im;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) return;
      stall_cnt++;
    end
    checks++;
    errors++;
    $display("FAIL send_pair_timeout: in_ready stayed 0 for 200 cycles");
  endtask

  // Send pairs [p_from..p_to] of fr_re/fr_im; queue expectations once the frame is complete.
  task automatic send_pairs(input int p_from, input int p_to, input bit push);
    for (int p = p_from; p <= p_to; p++)
      send_pair(fr_re[2*p], fr_im[2*p], fr_re[2*p+1], fr_im[2*p+1]);
    in_valid = 1'b0;
    if (push) begin
      for (int k = 0; k < N; k++) begin
        sb_t e;
        e.re = fr_re[brv[k]];
        e.im = fr_im[brv[k]];
        e.idx = 4'(k);
        e.last = (k == N-1);
        sb.push_back(e);
      end
    end
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 300; t++) begin
      if (sb.size() == 0 && !out_valid) return;
      @(posedge clk);
      #1;
    end
    checks++;
    errors++;
    $display("FAIL drain_timeout: %0d samples still expected", sb.size());
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_idx", 32'(out_idx), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_err_drop", 32'(err_drop), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Test 1: re = stream index, im = 0; check first-sample latency.
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin fr_re[i] = 16'(i); fr_im[i] = 16'h0000; end
    send_pairs(0, 6, 1'b0);
    chk("t1_valid_before_last", 32'(out_valid), 0);
    send_pairs(7, 7, 1'b1);
    chk("t1_valid_after_last", 32'(out_valid), 1);
    wait_drain();

    // Test 2: back-to-back frames A and B with no input stalls.
    stall_cnt = 0;
    for (int i = 0; i < N; i++) begin fr_re[i] = 16'h0100 + 16'(i); fr_im[i] = 16'h0010 + 16'(i); end
    send_pairs(0, 7, 1'b1);
    for (int i = 0; i < N; i++) begin fr_re[i] = 16'h0200 + 16'(i); fr_im[i] = 16'h0020 + 16'(i); end
    send_pairs(0, 7, 1'b1);
    chk("t2_no_stall", 32'(stall_cnt), 0);
    wait_drain();
    chk("t2_err_drop", 32'(err_drop), 0);

    // Test 3: both banks full, dropped pair, drain of first bank reopens input.
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) begin fr_re[i] = 16'h0300 + 16'(i); fr_im[i] = 16'h0030 + 16'(i); end
    send_pairs(0, 7, 1'b1);
    for (int i = 0; i < N; i++) begin fr_re[i] = 16'h0400 + 16'(i); fr_im[i] = 16'h0040 + 16'(i); end
    send_pairs(0, 7, 1'b1);
    chk("t3_in_ready_full", 32'(in_ready), 0);
    in_valid = 1'b1;
    in_y0_re = 16'h7777; in_y0_im = 16'h7777; in_y1_re = 16'h6666; in_y1_im = 16'h6666;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("t3_err_drop_set", 32'(err_drop), 1);
    base = out_cnt;
    out_ready = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(posedge clk);
      #1;
      if (out_cnt == base + 15) chk("t3_ready_before_drain", 32'(in_ready), 0);
      if (out_cnt == base + 16) begin
        chk("t3_ready_after_drain", 32'(in_ready), 1);
        break;
      end
    end
    wait_drain();
    chk("t3_err_drop_sticky", 32'(err_drop), 1);

    // Test 4: out_ready toggles every cycle while the frame streams out.
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) begin fr_re[i] = 16'h0500 + 16'(i); fr_im[i] = 16'h0050 + 16'(i); end
    send_pairs(0, 7, 1'b1);
    for (int t = 0; t < 40; t++) begin
      out_ready = ~out_ready;
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    wait_drain();

    // Test 5: reset after pair 3, then a fresh full frame.
    for (int i = 0; i < N; i++) begin fr_re[i] = 16'h0EE0 + 16'(i); fr_im[i] = 16'h0EE0; end
    send_pairs(0, 3, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("t5_rst_out_valid", 32'(out_valid), 0);
    chk("t5_rst_in_ready", 32'(in_ready), 1);
    chk("t5_rst_out_idx", 32'(out_idx), 0);
    chk("t5_rst_out_last", 32'(out_last), 0);
    chk("t5_rst_err_drop", 32'(err_drop), 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin fr_re[i] = 16'h0600 + 16'(i); fr_im[i] = 16'h0060 + 16'(i); end
    send_pairs(0, 7, 1'b1);
    wait_drain();

    // Test 6: negative Q7.8 sample at stream index 5 must appear bit-exact at k = 10.
    for (int i = 0; i < N; i++) begin fr_re[i] = 16'h0700 + 16'(i); fr_im[i] = 16'h0070 + 16'(i); end
    fr_re[5] = 16'hFF80;
    fr_im[5] = 16'h8000;
    send_pairs(0, 7, 1'b1);
    wait_drain();

    chk("total_outputs", 32'(out_cnt), 128);
    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
